split_rejection_sampler: RTL and testbench
==========================================

Name: split_rejection_sampler

Overview:
- Sequential stage directly upstream of a split constraint checker; the checker is a purely combinational module with packed variable inputs and a single `x` output.
- Generates pseudo-random candidate assignments for the split's packed variable bus, drives them into the checker and samples its `x` (sat) result.
- Retries until a candidate satisfies the constraints or the try budget runs out.
- Emits accepted samples over a valid/ready handshake to the downstream solution collector.

Parameters:
- VEC_W, 64, total packed width of the split's variable bus (concatenation of all var_N inputs, var_0 in LSBs).
- MAX_TRIES, 1024, candidates evaluated per request before giving up (>=1).
- DEFAULT_SEED, 32'h1, LFSR seed applied at reset.
- TRY_W, $clog2(MAX_TRIES+1), width of the try counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- seed_load  in  1  load seed into generators (honoured only in IDLE)
- seed  in  32  seed value
- start  in  1  request one satisfying sample (honoured only in IDLE)
- cand  out  VEC_W  registered candidate driven to the checker's variable inputs
- sat  in  1  checker result `x` for current `cand` (combinational from `cand`)
- sample_valid  out  1  accepted sample available
- sample_ready  in  1  downstream accepts sample
- sample_data  out  VEC_W  accepted assignment
- busy  out  1  high in every state except IDLE
- fail  out  1  one-cycle pulse: budget exhausted, no sample
- try_count  out  TRY_W  candidates evaluated for the current/last request

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0 (`cand`, `sample_data`, `try_count` all zero); every generator word reloaded from DEFAULT_SEED-derived seeds.
  - Reset overrides any state, including mid-CHECK or HOLD; a pending sample is discarded.
- Generators: NW = ceil(VEC_W/32) 32-bit Galois LFSRs, taps 32'h80200003, shift right, xor taps when the shifted-out bit is 1.
  - Word i seed = seed ^ (i * 32'h9E3779B9); a zero result is replaced by 32'h1.
  - All words step together; `cand` = low VEC_W bits of {word NW-1 .. word 0}.
- seed_load in IDLE: reseed all words next cycle. If seed_load and start coincide, seed_load takes priority and start is ignored.
- FSM:
  - IDLE: on start, clear try_count and go to GEN.
  - GEN (1 cycle): step LFSRs; register new `cand`; try_count += 1; go to CHECK.
  - CHECK (1 cycle): sample `sat`.
    - sat=1: `sample_data` <= `cand`, sample_valid <= 1, go to HOLD.
    - sat=0 and try_count==MAX_TRIES: fail pulse next cycle, go to IDLE.
    - Otherwise go to GEN.
  - HOLD: sample_valid and sample_data stay stable until sample_valid & sample_ready. On that handshake sample_valid drops next cycle and the state returns to IDLE. `cand` is frozen.
- Latency: start at cycle 0 → first `cand` visible cycle 1 → sat sampled cycle 2 → sample_valid high cycle 3 on first-try success. Each extra try adds 2 cycles.
- start is ignored while busy; no queuing.
- try_count holds its final value in IDLE until the next start.
- `sat` is only meaningful in CHECK; `sat` values in other states are ignored.

Decomposition:
- Package split_sampler_pkg: state enum {IDLE, GEN, CHECK, HOLD}, LFSR_TAPS=32'h80200003, SEED_STRIDE=32'h9E3779B9.
- One sub-module, lfsr32_word: load/step/seed ports, zero-seed guard, 32-bit state output; instantiated NW times via generate.

Test Plan:
- sat tied 1, start at cycle 0 → sample_valid=1 at cycle 3, sample_data equals first LFSR output for DEFAULT_SEED, try_count=1.
- sat tied 0, MAX_TRIES=4 → four GEN/CHECK pairs, fail pulses exactly one cycle at cycle 9, sample_valid never asserts, busy low from cycle 9, try_count=4.
- Checker sat = |(cand[7:0]*cand[12:8]), VEC_W=13 → accepted sample_data has both fields nonzero; compare against a reference-model LFSR sequence that skips rejected candidates.
- Accept on try 1, sample_ready low for 5 cycles then high → sample_data/sample_valid stable throughout, single transfer, IDLE next cycle.
- seed_load seed=0 → word 0 uses 32'h1, word 1 uses 32'h9E3779B9; start pulses while busy and start coincident with seed_load → ignored.
- rst asserted in CHECK and in HOLD → next cycle all outputs 0, IDLE; a following start reproduces the DEFAULT_SEED sequence.

Source files
------------

// File: rtl/split_sampler_pkg.sv
// Shared definitions for the split rejection sampler.
//   state_t     : sampler FSM states
//   LFSR_TAPS   : Galois feedback taps of each 32-bit generator word
//   SEED_STRIDE : per-word seed offset (golden-ratio constant)
//   lfsr_step() : one right-shift Galois step of a 32-bit word
package split_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      CHECK,
      HOLD
   } state_t;

   localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
   localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ LFSR_TAPS;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr32_word.sv
// One 32-bit Galois LFSR word of the candidate generator.
//   clk   : rising-edge clock
//   load  : replace state with seed (zero seed mapped to 1); wins over step
//   step  : advance the word by one Galois step
//   seed  : seed value for this word
//   state : current 32-bit LFSR state
module lfsr32_word
   import split_sampler_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   // An all-zero state would lock the LFSR, so it is never loaded.
   logic [31:0] seed_safe;
   assign seed_safe = (seed == 32'h0) ? 32'h1 : seed;

   always_ff @(posedge clk) begin
      if (load) begin
         state <= seed_safe;
      end else if (step) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/split_rejection_sampler.sv
// Rejection sampler feeding a combinational split constraint checker.
// Draws pseudo-random candidates, drives them on cand, samples the
// checker's sat result and retries until success or MAX_TRIES candidates.
//   clk, rst      : clock, synchronous active-high reset
//   seed_load/seed: reseed all generator words (IDLE only, beats start)
//   start         : request one satisfying sample (IDLE only)
//   cand          : registered candidate to the checker's variable bus
//   sat           : checker verdict for cand (used in CHECK only)
//   sample_valid/sample_ready/sample_data : accepted-sample handshake
//   busy          : high whenever not IDLE
//   fail          : one-cycle pulse when the try budget is exhausted
//   try_count     : candidates evaluated for the current/last request
module split_rejection_sampler
   import split_sampler_pkg::*;
#(
   parameter int          VEC_W        = 64,
   parameter int          MAX_TRIES    = 1024,
   parameter logic [31:0] DEFAULT_SEED = 32'h1,
   parameter int          TRY_W        = $clog2(MAX_TRIES + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   input  logic             start,
   output logic [VEC_W-1:0] cand,
   input  logic             sat,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [VEC_W-1:0] sample_data,
   output logic             busy,
   output logic             fail,
   output logic [TRY_W-1:0] try_count
);

   localparam int               NW        = (VEC_W + 31) / 32;
   localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

   state_t            state, state_nxt;
   logic              gen_step;
   logic              take_sample;
   logic              try_clear;
   logic              fail_nxt;
   logic              lfsr_reseed;
   logic              lfsr_load;
   logic [31:0]       base_seed;
   logic [NW*32-1:0]  words_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gen_step    = 1'b0;
      take_sample = 1'b0;
      try_clear   = 1'b0;
      fail_nxt    = 1'b0;
      lfsr_reseed = 1'b0;
      case (state)
         IDLE: begin
            if (seed_load) begin
               lfsr_reseed = 1'b1;
            end else if (start) begin
               try_clear = 1'b1;
               state_nxt = GEN;
            end
         end
         GEN: begin
            gen_step  = 1'b1;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (sat) begin
               take_sample = 1'b1;
               state_nxt   = HOLD;
            end else if (try_count == TRY_LIMIT) begin
               fail_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = GEN;
            end
         end
         HOLD: begin
            if (sample_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign sample_valid = (state == HOLD);

   // Reset reloads the generators from DEFAULT_SEED through the same load
   // path used by seed_load.
   assign lfsr_load = rst | lfsr_reseed;
   assign base_seed = rst ? DEFAULT_SEED : seed;

   for (genvar i = 0; i < NW; i++) begin : g_word
      localparam logic [31:0] WORD_OFS = SEED_STRIDE * 32'(i);
      logic [31:0] word_state;

      lfsr32_word u_word (
         .clk   (clk),
         .load  (lfsr_load),
         .step  (gen_step),
         .seed  (base_seed ^ WORD_OFS),
         .state (word_state)
      );

      // The candidate is the post-step value so cand and the generator
      // state advance on the same edge.
      assign words_next[i*32 +: 32] = lfsr_step(word_state);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand        <= '0;
         sample_data <= '0;
         try_count   <= '0;
         fail        <= 1'b0;
      end else begin
         fail <= fail_nxt;
         if (try_clear) begin
            try_count <= '0;
         end else if (gen_step) begin
            try_count <= try_count + TRY_W'(1);
         end
         if (gen_step) begin
            cand <= words_next[VEC_W-1:0];
         end
         if (take_sample) begin
            sample_data <= cand;
         end
      end
   end

endmodule

// File: tb/tb_split_rejection_sampler.sv
// Self-checking bench for split_rejection_sampler (VEC_W=48, MAX_TRIES=4).
// A request-level model drives the stimulus and keeps the expected outputs
// up to date; a negedge process compares them with the DUT every cycle.
module tb_split_rejection_sampler;

   localparam int          VEC_W     = 48;
   localparam int          MAX_TRIES = 4;
   localparam int          TRY_W     = $clog2(MAX_TRIES + 1);
   localparam logic [31:0] DEF_SEED  = 32'h1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             seed_load = 1'b0;
   logic [31:0]      seed = 32'h0;
   logic             start = 1'b0;
   logic [VEC_W-1:0] cand;
   logic             sat;
   logic             sample_valid;
   logic             sample_ready = 1'b0;
   logic [VEC_W-1:0] sample_data;
   logic             busy;
   logic             fail;
   logic [TRY_W-1:0] try_count;

   always #5 clk = ~clk;

   split_rejection_sampler #(
      .VEC_W        (VEC_W),
      .MAX_TRIES    (MAX_TRIES),
      .DEFAULT_SEED (DEF_SEED)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .seed_load    (seed_load),
      .seed         (seed),
      .start        (start),
      .cand         (cand),
      .sat          (sat),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .busy         (busy),
      .fail         (fail),
      .try_count    (try_count)
   );

   // Checker stand-in: 0 = never, 1 = always, 2 = product of two fields,
   // 3 = low two bits both set.
   int          sat_mode = 0;
   logic [12:0] prod;
   always_comb begin
      prod = 13'(cand[7:0]) * 13'(cand[12:8]);
      case (sat_mode)
         0:       sat = 1'b0;
         1:       sat = 1'b1;
         2:       sat = |prod;
         default: sat = &cand[1:0];
      endcase
   end

   // ---------------- reference model ----------------
   logic [31:0] m_word [2];

   function automatic logic [31:0] m_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   function automatic logic [31:0] m_seed_of(input logic [31:0] s, input int i);
      logic [31:0] v;
      v = s ^ (32'(i) * 32'h9E3779B9);
      return (v == 32'h0) ? 32'h1 : v;
   endfunction

   task automatic m_reseed(input logic [31:0] s);
      m_word[0] = m_seed_of(s, 0);
      m_word[1] = m_seed_of(s, 1);
   endtask

   task automatic m_advance(output logic [VEC_W-1:0] c);
      logic [63:0] cat;
      m_word[0] = m_next(m_word[0]);
      m_word[1] = m_next(m_word[1]);
      cat = {m_word[1], m_word[0]};
      c = cat[VEC_W-1:0];
   endtask

   function automatic bit m_accepts(input logic [VEC_W-1:0] c);
      case (sat_mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (c[7:0] != 8'h0) && (c[12:8] != 5'h0);
         default: return c[1:0] == 2'b11;
      endcase
   endfunction

   logic [VEC_W-1:0] exp_cand, exp_sdata;
   logic             exp_sv, exp_busy, exp_fail;
   logic [TRY_W-1:0] exp_try;

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cand",         64'(cand),         64'(exp_cand));
         chk("sample_data",  64'(sample_data),  64'(exp_sdata));
         chk("sample_valid", 64'(sample_valid), 64'(exp_sv));
         chk("busy",         64'(busy),         64'(exp_busy));
         chk("fail",         64'(fail),         64'(exp_fail));
         chk("try_count",    64'(try_count),    64'(exp_try));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; seed_load = 1'b0; sample_ready = 1'b0;
      tick();
      rst = 1'b0;
      exp_cand = '0; exp_sdata = '0; exp_sv = 1'b0;
      exp_busy = 1'b0; exp_fail = 1'b0; exp_try = '0;
      m_reseed(DEF_SEED);
   endtask

   task automatic seed_cmd(input logic [31:0] s, input bit with_start);
      seed = s; seed_load = 1'b1; start = with_start;
      tick();
      seed_load = 1'b0; start = 1'b0;
      m_reseed(s);
   endtask

   // One request. abort_at: 0 none, 1 reset in CHECK, 2 reset in HOLD.
   // noise keeps start/seed_load toggling while busy. ev_cyc reports the
   // cycle (start cycle = 0) when sample_valid or fail first shows.
   task automatic request(input int mode, input int ready_delay, input int abort_at,
                          input bit noise, output logic [VEC_W-1:0] got,
                          output bit accepted, output int ev_cyc);
      logic [VEC_W-1:0] c;
      int tries;
      int cyc;
      sat_mode = mode;
      got = '0; accepted = 1'b0; ev_cyc = -1; tries = 0;
      start = 1'b1;
      tick(); cyc = 1;
      start = 1'b0;
      exp_try = '0; exp_busy = 1'b1; exp_fail = 1'b0;
      forever begin
         if (noise) begin start = 1'b1; seed_load = 1'b1; seed = $urandom; end
         tick(); cyc++;
         m_advance(c);
         tries++;
         exp_cand = c;
         exp_try  = TRY_W'(tries);
         if (abort_at == 1) begin do_reset(); return; end
         tick(); cyc++;
         if (m_accepts(c)) break;
         if (tries == MAX_TRIES) begin
            start = 1'b0; seed_load = 1'b0;
            exp_busy = 1'b0; exp_fail = 1'b1; ev_cyc = cyc;
            tick();
            exp_fail = 1'b0;
            return;
         end
      end
      exp_sv = 1'b1; exp_sdata = c; got = c; accepted = 1'b1; ev_cyc = cyc;
      for (int k = 0; k < ready_delay; k++) tick();
      if (abort_at == 2) begin do_reset(); return; end
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0; start = 1'b0; seed_load = 1'b0;
      exp_sv = 1'b0; exp_busy = 1'b0;
   endtask

   logic [VEC_W-1:0] got;
   bit               acc;
   int               ev;

   initial begin
      m_reseed(DEF_SEED);
      tick();
      do_reset();
      chk_en = 1'b1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_cand", 64'(cand), 64'd0);
      chk("reset_try",  64'(try_count), 64'd0);

      // first-try acceptance with the default seed
      request(1, 0, 0, 1'b0, got, acc, ev);
      chk("first_sample", 64'(got), 64'h0000_BCDC_8020_0003);
      chk("first_latency", 64'(ev), 64'd3);
      chk("first_try_count", 64'(try_count), 64'd1);

      // budget exhaustion
      request(0, 0, 0, 1'b0, got, acc, ev);
      chk("fail_cycle", 64'(ev), 64'd9);
      chk("fail_try_count", 64'(try_count), 64'd4);
      tick();

      // field-product checker, varying ready delay, noise while busy
      for (int r = 0; r < 6; r++) begin
         request(2, r % 3, 0, r[0], got, acc, ev);
         if (acc) chk("fields_nonzero", 64'((got[7:0] != 0) && (got[12:8] != 0)), 64'd1);
      end

      // long hold before ready
      request(1, 5, 0, 1'b1, got, acc, ev);

      // retries with a 25% acceptance checker
      for (int r = 0; r < 8; r++) request(3, r % 2, 0, r[1], got, acc, ev);

      // seed 0 with a coincident start: reseed only
      seed_cmd(32'h0, 1'b1);
      tick();
      chk("seed_start_ignored", 64'(busy), 64'd0);
      request(1, 0, 0, 1'b0, got, acc, ev);
      chk("seed0_sample", 64'(got), 64'h0000_BCDF_8020_0003);

      // reset during CHECK, then the default sequence again
      request(1, 0, 1, 1'b0, got, acc, ev);
      chk("rst_check_valid", 64'(sample_valid), 64'd0);
      request(1, 0, 0, 1'b0, got, acc, ev);
      chk("after_rst_check", 64'(got), 64'h0000_BCDC_8020_0003);

      // reset during HOLD discards the pending sample
      request(1, 2, 2, 1'b0, got, acc, ev);
      chk("rst_hold_data", 64'(sample_data), 64'd0);
      request(1, 1, 0, 1'b0, got, acc, ev);
      chk("after_rst_hold", 64'(got), 64'h0000_BCDC_8020_0003);

      // arbitrary seed, mixed checkers
      seed_cmd(32'hC0FFEE11, 1'b0);
      for (int r = 0; r < 4; r++) request(2 + (r % 2), r, 0, 1'b1, got, acc, ev);

      tick();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
